// File: rtl/if_fetch_unit.sv
// Instruction fetch front-end: issues in-order imem requests under a credit limit,
// pairs each response with its PC and buffers it for decode; a flush discards in-flight work.
module if_fetch_unit #(
  parameter int WIDTH           = 32,
  parameter int FQ_DEPTH        = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_in,
  output logic             pc_halt,
  input  logic             flush,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  output logic             if_valid,
  input  logic             if_ready,
  output logic [WIDTH-1:0] if_instr,
  output logic [WIDTH-1:0] if_pc,
  output logic [WIDTH-1:0] if_pc_plus4
);

  localparam int FQ_AW = $clog2(FQ_DEPTH);
  localparam int TQ_AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int FQ_CW = $clog2(FQ_DEPTH) + 1;
  localparam int TQ_CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int SW    = ((FQ_CW > TQ_CW) ? FQ_CW : TQ_CW) + 1;

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] instr;
  } fq_entry_t;

  fq_entry_t        fq_mem [FQ_DEPTH];
  logic [FQ_AW-1:0] fq_rd_ptr, fq_wr_ptr;
  logic [FQ_CW-1:0] fq_count;

  logic [WIDTH-1:0] tq_mem [MAX_OUTSTANDING];
  logic [TQ_AW-1:0] tq_rd_ptr, tq_wr_ptr;
  logic [TQ_CW-1:0] tag_count;
  logic [TQ_CW-1:0] drop_cnt;

  logic [SW-1:0]    outstanding, occupancy;
  logic [TQ_CW-1:0] flush_drop;
  logic             credit_ok, fire, rsp_legal, rsp_drop, rsp_enq, fq_pop;

  // Tag pointers wrap explicitly so a single-entry tag queue stays in range.
  function automatic logic [TQ_AW-1:0] tq_next(input logic [TQ_AW-1:0] p);
    return (p == TQ_AW'(MAX_OUTSTANDING - 1)) ? '0 : p + TQ_AW'(1);
  endfunction

  always_comb begin
    outstanding    = SW'(tag_count) + SW'(drop_cnt);
    occupancy      = SW'(tag_count) + SW'(fq_count);
    credit_ok      = (occupancy < SW'(FQ_DEPTH)) && (outstanding < SW'(MAX_OUTSTANDING));
    imem_req_valid = credit_ok && !flush && !rst;
    imem_req_addr  = pc_in;
    fire           = imem_req_valid && imem_req_ready;
    pc_halt        = !fire && !flush;
    // A response with nothing outstanding is ignored entirely.
    rsp_legal      = imem_rsp_valid && (outstanding != '0);
    rsp_drop       = rsp_legal && (drop_cnt != '0);
    rsp_enq        = rsp_legal && (drop_cnt == '0) && !flush;
    flush_drop     = TQ_CW'(outstanding - SW'(rsp_legal));
    if_valid       = (fq_count != '0) && !flush;
    fq_pop         = if_valid && if_ready;
    if_pc          = fq_mem[fq_rd_ptr].pc;
    if_instr       = fq_mem[fq_rd_ptr].instr;
    if_pc_plus4    = fq_mem[fq_rd_ptr].pc + WIDTH'(4);
  end

  // NOTE: storage is cleared on reset so the head outputs read a defined 0/4 before the first fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FQ_DEPTH; i++) fq_mem[i] <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) tq_mem[i] <= '0;
    end else begin
      if (rsp_enq) fq_mem[fq_wr_ptr] <= '{pc: tq_mem[tq_rd_ptr], instr: imem_rsp_data};
      if (fire) tq_mem[tq_wr_ptr] <= pc_in;
    end
  end

  // NOTE: all state updates use <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      fq_rd_ptr <= '0;
      fq_wr_ptr <= '0;
      fq_count  <= '0;
      tq_rd_ptr <= '0;
      tq_wr_ptr <= '0;
      tag_count <= '0;
      drop_cnt  <= '0;
    end else if (flush) begin
      fq_rd_ptr <= '0;
      fq_wr_ptr <= '0;
      fq_count  <= '0;
      tq_rd_ptr <= '0;
      tq_wr_ptr <= '0;
      tag_count <= '0;
      drop_cnt  <= flush_drop;
    end else begin
      if (fire) tq_wr_ptr <= tq_next(tq_wr_ptr);
      if (rsp_enq) begin
        tq_rd_ptr <= tq_next(tq_rd_ptr);
        fq_wr_ptr <= fq_wr_ptr + FQ_AW'(1);
      end
      if (fq_pop) fq_rd_ptr <= fq_rd_ptr + FQ_AW'(1);
      if (rsp_drop) drop_cnt <= drop_cnt - TQ_CW'(1);
      tag_count <= tag_count + TQ_CW'(fire) - TQ_CW'(rsp_enq);
      fq_count  <= fq_count + FQ_CW'(rsp_enq) - FQ_CW'(fq_pop);
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: models the PC register and an in-order memory, scoreboards
// every instruction handed to decode, and runs one task per scenario.
module tb_if_fetch_unit;

  localparam int MAX_OUT = 2;

  logic        clk, rst, flush, pc_halt;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic        if_valid, if_ready;
  logic [31:0] pc_in, imem_req_addr, imem_rsp_data, if_instr, if_pc, if_pc_plus4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  exp_t        exp_q[$];
  mreq_t       mem_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          mem_lat = 1;
  logic [31:0] flush_target = 32'h0;

  if_fetch_unit #(.WIDTH(32), .FQ_DEPTH(4), .MAX_OUTSTANDING(MAX_OUT)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_halt(pc_halt), .flush(flush),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // Environment: PC register, in-order memory and the decode-side scoreboard.
  // Outputs are sampled on the falling edge; inputs change 1 unit after the rising edge.
  initial begin : env
    logic [31:0] nxt_pc, nxt_rd;
    logic        nxt_rv;
    exp_t        e;
    mreq_t       m;
    pc_in          = 32'h0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      cyc++;
      nxt_pc = pc_in;
      nxt_rv = 1'b0;
      nxt_rd = 32'h0;
      if (rst) begin
        exp_q.delete();
        mem_q.delete();
        nxt_pc = 32'h0;
      end else begin
        if (imem_req_valid) begin
          n_cmp++;
          if (imem_req_addr !== pc_in) begin
            n_err++;
            $display("FAIL req_addr: got %h expected %h", imem_req_addr, pc_in);
          end
          n_cmp++;
          if (mem_q.size() + int'(imem_rsp_valid) >= MAX_OUT) begin
            n_err++;
            $display("FAIL credit: request with %0d in flight, limit %0d",
                     mem_q.size() + int'(imem_rsp_valid), MAX_OUT);
          end
        end
        if (if_valid && if_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_unexpected: got pc %h instr %h expected nothing", if_pc, if_instr);
          end else begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({if_pc, if_instr, if_pc_plus4} !== {e.pc, e.instr, e.pc + 32'd4}) begin
              n_err++;
              $display("FAIL sb_entry: got pc %h instr %h pc4 %h expected pc %h instr %h pc4 %h",
                       if_pc, if_instr, if_pc_plus4, e.pc, e.instr, e.pc + 32'd4);
            end
          end
        end
        if (flush) exp_q.delete();
        if (imem_req_valid && imem_req_ready) begin
          exp_q.push_back('{pc: imem_req_addr, instr: instr_of(imem_req_addr)});
          mem_q.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
        end
        nxt_pc = flush ? flush_target : (pc_halt ? pc_in : pc_in + 32'd4);
        if (mem_q.size() > 0 && mem_q[0].due <= cyc + 1) begin
          m      = mem_q.pop_front();
          nxt_rv = 1'b1;
          nxt_rd = instr_of(m.addr);
        end
      end
      @(posedge clk);
      #1;
      pc_in          = nxt_pc;
      imem_rsp_valid = nxt_rv;
      imem_rsp_data  = nxt_rd;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; if_ready = 1'b1; imem_req_ready = 1'b1; mem_lat = 1;
    step();
    @(negedge clk);
    n_cmp++;
    if ({imem_req_valid, pc_halt, if_valid, if_pc, if_instr, if_pc_plus4} !==
        {1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h4}) begin
      n_err++;
      $display("FAIL reset_state: req_valid=%b halt=%b if_valid=%b pc=%h instr=%h pc4=%h expected 0 1 0 0 0 4",
               imem_req_valid, pc_halt, if_valid, if_pc, if_instr, if_pc_plus4);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_straight();
    logic [31:0] exp_addr;
    exp_addr = 32'h0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({imem_req_valid, pc_halt, imem_req_addr} !== {1'b1, 1'b0, exp_addr}) begin
        n_err++;
        $display("FAIL straight_req[%0d]: valid=%b halt=%b addr=%h expected 1 0 %h",
                 i, imem_req_valid, pc_halt, imem_req_addr, exp_addr);
      end
      if (i >= 2) begin
        n_cmp++;
        if ({if_valid, if_pc} !== {1'b1, 32'((i - 2) * 4)}) begin
          n_err++;
          $display("FAIL straight_out[%0d]: valid=%b pc=%h expected 1 %h",
                   i, if_valid, if_pc, 32'((i - 2) * 4));
        end
      end
      exp_addr += 32'd4;
      step();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    bit          resumed;
    if_ready = 1'b0;
    repeat (8) step();
    @(negedge clk);
    n_cmp++;
    if ({imem_req_valid, pc_halt, if_valid} !== 3'b011) begin
      n_err++;
      $display("FAIL bp_full: req_valid=%b halt=%b if_valid=%b expected 0 1 1",
               imem_req_valid, pc_halt, if_valid);
    end
    held = pc_in;
    step();
    @(negedge clk);
    n_cmp++;
    if ({imem_req_valid, pc_halt, imem_req_addr} !== {1'b0, 1'b1, held}) begin
      n_err++;
      $display("FAIL bp_frozen: req_valid=%b halt=%b addr=%h expected 0 1 %h",
               imem_req_valid, pc_halt, imem_req_addr, held);
    end
    step();
    if_ready = 1'b1;
    resumed  = 1'b0;
    for (int k = 0; k < 6 && !resumed; k++) begin
      @(negedge clk);
      if (imem_req_valid) begin
        resumed = 1'b1;
        n_cmp++;
        if (imem_req_addr !== held) begin
          n_err++;
          $display("FAIL bp_resume_addr: got %h expected %h", imem_req_addr, held);
        end
      end
      step();
    end
    if (!resumed) begin
      n_cmp++;
      n_err++;
      $display("FAIL bp_resume_timeout: got no request expected one within 6 cycles");
    end
  endtask

  task automatic test_mem_stall();
    logic [31:0] held;
    repeat (4) step();
    imem_req_ready = 1'b0;
    held = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) held = imem_req_addr;
      n_cmp++;
      if ({imem_req_valid, pc_halt, imem_req_addr} !== {1'b1, 1'b1, held}) begin
        n_err++;
        $display("FAIL stall[%0d]: valid=%b halt=%b addr=%h expected 1 1 %h",
                 i, imem_req_valid, pc_halt, imem_req_addr, held);
      end
      step();
    end
    imem_req_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({imem_req_valid, pc_halt, imem_req_addr} !== {1'b1, 1'b0, held}) begin
      n_err++;
      $display("FAIL stall_release: valid=%b halt=%b addr=%h expected 1 0 %h",
               imem_req_valid, pc_halt, imem_req_addr, held);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (imem_req_addr !== held + 32'd4) begin
      n_err++;
      $display("FAIL stall_next_addr: got %h expected %h", imem_req_addr, held + 32'd4);
    end
    step();
  endtask

  task automatic test_flush();
    rst = 1'b1; imem_req_ready = 1'b0; if_ready = 1'b1; mem_lat = 2;
    step();
    rst = 1'b0; flush = 1'b1; flush_target = 32'h10;
    step();
    flush = 1'b0; imem_req_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h10 + 32'(4 * i)}) begin
        n_err++;
        $display("FAIL flush_setup[%0d]: valid=%b addr=%h expected 1 %h",
                 i, imem_req_valid, imem_req_addr, 32'h10 + 32'(4 * i));
      end
      step();
    end
    flush = 1'b1; flush_target = 32'h100;
    @(negedge clk);
    n_cmp++;
    if ({imem_rsp_valid, if_valid, imem_req_valid, pc_halt} !== 4'b1000) begin
      n_err++;
      $display("FAIL flush_cycle: rsp=%b if_valid=%b req_valid=%b halt=%b expected 1 0 0 0",
               imem_rsp_valid, if_valid, imem_req_valid, pc_halt);
    end
    step();
    flush = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h100}) begin
      n_err++;
      $display("FAIL flush_target_req: valid=%b addr=%h expected 1 00000100",
               imem_req_valid, imem_req_addr);
    end
    step();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if (if_valid !== 1'b0) begin
        n_err++;
        $display("FAIL flush_stale_dropped[%0d]: if_valid=%b pc=%h expected 0", i, if_valid, if_pc);
      end
      step();
    end
    @(negedge clk);
    n_cmp++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h100, instr_of(32'h100)}) begin
      n_err++;
      $display("FAIL flush_first_out: valid=%b pc=%h instr=%h expected 1 00000100 %h",
               if_valid, if_pc, if_instr, instr_of(32'h100));
    end
    step();
  endtask

  task automatic test_back_to_back();
    bit seen;
    repeat (3) step();
    for (int i = 0; i < 2; i++) begin
      flush = 1'b1; flush_target = (i == 0) ? 32'h200 : 32'h300;
      @(negedge clk);
      n_cmp++;
      if ({imem_req_valid, if_valid, pc_halt} !== 3'b000) begin
        n_err++;
        $display("FAIL b2b_flush[%0d]: req_valid=%b if_valid=%b halt=%b expected 0 0 0",
                 i, imem_req_valid, if_valid, pc_halt);
      end
      step();
    end
    flush = 1'b0;
    seen  = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      if (imem_req_valid) begin
        seen = 1'b1;
        n_cmp++;
        if (imem_req_addr !== 32'h300) begin
          n_err++;
          $display("FAIL b2b_req_addr: got %h expected 00000300", imem_req_addr);
        end
      end
      step();
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL b2b_req_timeout: got no request expected one within 8 cycles");
    end
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      if (if_valid) begin
        seen = 1'b1;
        n_cmp++;
        if (if_pc !== 32'h300) begin
          n_err++;
          $display("FAIL b2b_first_out: got pc %h expected 00000300", if_pc);
        end
      end
      step();
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL b2b_out_timeout: got no instruction expected one within 8 cycles");
    end
  endtask

  task automatic test_wrap_random();
    mem_lat  = 1;
    if_ready = 1'b0;
    repeat (8) step();
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() == 0 || {if_valid, if_pc} !== {1'b1, exp_q[0].pc}) begin
      n_err++;
      $display("FAIL full_head: valid=%b pc=%h expected 1 %h", if_valid, if_pc,
               (exp_q.size() == 0) ? 32'hx : exp_q[0].pc);
    end
    step();
    for (int i = 0; i < 80; i++) begin
      if_ready       = ($urandom_range(0, 3) != 0);
      imem_req_ready = ($urandom_range(0, 4) != 0);
      step();
    end
    if_ready = 1'b1; imem_req_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit seen;
    mem_lat = 2; if_ready = 1'b0;
    repeat (6) step();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({imem_req_valid, pc_halt} !== 2'b01) begin
      n_err++;
      $display("FAIL rst_mid_req: req_valid=%b halt=%b expected 0 1", imem_req_valid, pc_halt);
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({if_valid, if_pc, if_instr, if_pc_plus4, imem_req_valid, pc_halt, imem_req_addr} !==
        {1'b0, 32'h0, 32'h0, 32'h4, 1'b1, 1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL rst_mid_state: if_valid=%b pc=%h instr=%h pc4=%h req=%b halt=%b addr=%h expected 0 0 0 4 1 0 0",
               if_valid, if_pc, if_instr, if_pc_plus4, imem_req_valid, pc_halt, imem_req_addr);
    end
    step();
    if_ready = 1'b1;
    seen     = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      if (if_valid) begin
        seen = 1'b1;
        n_cmp++;
        if ({if_pc, if_instr} !== {32'h0, instr_of(32'h0)}) begin
          n_err++;
          $display("FAIL rst_mid_first_out: pc=%h instr=%h expected 0 %h", if_pc, if_instr, instr_of(32'h0));
        end
      end
      step();
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL rst_mid_timeout: got no instruction expected one within 8 cycles");
    end
    repeat (6) step();
  endtask

  task automatic test_drain();
    imem_req_ready = 1'b0; if_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d instructions never delivered expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_straight();
    test_backpressure();
    test_mem_stall();
    test_flush();
    test_back_to_back();
    test_wrap_random();
    test_reset_mid();
    test_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
